// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM encoding, frame geometry and baud divisors.
// Frame length follows UART_RX_PARITY_EN (8N1 = 10 bits, 8E1 = 11 bits).
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        LOAD = 2'd2,
        DAV  = 2'd3
    } state_e;

    localparam int FRAME_LEN_8N1 = 10;
    localparam int FRAME_LEN_8E1 = 11;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_LEN = FRAME_LEN_8E1;
`else
    localparam int FRAME_LEN = FRAME_LEN_8N1;
`endif

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    // Bit periods in clk cycles at 100 MHz
    localparam int B115200 = 868;
    localparam int B57600  = 1736;
    localparam int B38400  = 2604;
    localparam int B19200  = 5208;
    localparam int B9600   = 10417;

endpackage

// File: rtl/baudgen_rx.sv
// baudgen_rx: mid-bit tick generator for the receiver.
// First tick M/2+1 cycles after clk_ena rises, then one every M cycles.
module baudgen_rx #(
    parameter int M = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int W = $clog2(M);
    localparam logic [W-1:0] TOP = W'(M - 1);
    localparam logic [W-1:0] MID = W'(M / 2);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    // Parked at TOP while disabled so the first enabled cycle wraps to 0
    always_comb begin
        div_d = TOP;
        if (clk_ena) begin
            if (div_q == TOP) begin
                div_d = '0;
            end else begin
                div_d = div_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= TOP;
        end else begin
            div_q <= div_d;
        end
    end

    assign clk_out = clk_ena && (div_q == MID);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receive engine; 8E1 with even parity when
// UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    logic [1:0]           sync_q, sync_d;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 rcv_q, rcv_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
`endif

    logic rx_s;
    logic bauden;
    logic tick;
    logic stop_ok;
    logic par_ok;

    assign rx_s   = sync_q[1];
    assign bauden = (state_q == RECV);

    baudgen_rx #(
        .M(BAUD)
    ) u_baudgen (
        .clk    (clk),
        .rst    (rst),
        .clk_ena(bauden),
        .clk_out(tick)
    );

    // Start bit must also have sampled low for the frame to be good
    assign stop_ok = shift_q[FRAME_LEN-1] & ~shift_q[0];
`ifdef UART_RX_PARITY_EN
    assign par_ok = ~^shift_q[9:1];
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[FRAME_LEN-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == '0 && rx_s) begin
                        state_d = IDLE;
                    end else if (cnt_q == LAST_BIT) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = DAV;
                if (!stop_ok) begin
                    ferr_d = 1'b1;
                end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
                    perr_d = 1'b1;
`endif
                end else begin
                    data_d = shift_q[8:1];
                    rcv_d  = 1'b1;
                end
            end
            DAV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '1;
            data_q  <= '0;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign rcv       = rcv_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q == RECV) || (state_q == LOAD);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at BAUD=16.
// Reference model works on whole frames and event queues.
module tb_uart_rx;

    localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // rx edge to rcv: 2 sync + 1 IDLE + (BAUD/2+1) + (NB-1) bits + 2
    localparam int LAT = BAUD / 2 + 6 + (NB - 1) * BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(
        .BAUD(BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rcv       (rcv),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int         rcv_cyc[$];
    logic [7:0] rcv_dat[$];
    int         ferr_cyc[$];
    int         perr_cyc[$];
    bit         overlap = 1'b0;
    logic [7:0] model_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (rcv) begin
                rcv_cyc.push_back(cyc);
                rcv_dat.push_back(data);
            end
            if (frame_err) ferr_cyc.push_back(cyc);
            if (parity_err) perr_cyc.push_back(cyc);
            if ((rcv && frame_err) || (rcv && parity_err)) overlap = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        rcv_cyc.delete();
        rcv_dat.delete();
        ferr_cyc.delete();
        perr_cyc.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one complete frame, LSB first; t0 is the cycle of the start edge
    task automatic send(input logic [7:0] d, input bit stop_good,
                        input bit par_flip, output int t0);
        logic [15:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_good;
`else
        bits[9]  = stop_good ^ (par_flip & 1'b0);
`endif
        t0 = cyc;
        for (int i = 0; i < NB; i++) begin
            rx = bits[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", data);
        end
        checks++;
        if ({rcv, busy, frame_err, parity_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {rcv, busy, frame_err, parity_err});
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_single();
        int t0;
        clear_q();
        send(8'h55, 1'b1, 1'b0, t0);
        idle(2 * BAUD);
        model_data = 8'h55;
        checks++;
        if (rcv_cyc.size() !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", rcv_cyc.size());
        end
        if (rcv_cyc.size() > 0) begin
            checks++;
            if (rcv_dat[0] !== 8'h55) begin
                errors++;
                $display("FAIL single_data: got %h want 55", rcv_dat[0]);
            end
            checks++;
            if (rcv_cyc[0] - t0 !== LAT) begin
                errors++;
                $display("FAIL single_latency: got %0d want %0d",
                         rcv_cyc[0] - t0, LAT);
            end
        end
        checks++;
        if (ferr_cyc.size() !== 0) begin
            errors++;
            $display("FAIL single_ferr: got %0d want 0", ferr_cyc.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        clear_q();
        send(8'hA3, 1'b1, 1'b0, t0);
        send(8'h0F, 1'b1, 1'b0, t1);
        idle(2 * BAUD);
        model_data = 8'h0F;
        checks++;
        if (rcv_cyc.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", rcv_cyc.size());
        end
        if (rcv_cyc.size() == 2) begin
            checks++;
            if (rcv_dat[0] !== 8'hA3 || rcv_dat[1] !== 8'h0F) begin
                errors++;
                $display("FAIL b2b_data: got %h %h want a3 0f",
                         rcv_dat[0], rcv_dat[1]);
            end
            checks++;
            if (rcv_cyc[1] - rcv_cyc[0] !== NB * BAUD) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d",
                         rcv_cyc[1] - rcv_cyc[0], NB * BAUD);
            end
            checks++;
            if (rcv_cyc[1] - t1 !== LAT) begin
                errors++;
                $display("FAIL b2b_latency: got %0d want %0d",
                         rcv_cyc[1] - t1, LAT);
            end
        end
    endtask

    task automatic test_glitch();
        clear_q();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(3 * BAUD);
        checks++;
        if (rcv_cyc.size() + ferr_cyc.size() + perr_cyc.size() !== 0) begin
            errors++;
            $display("FAIL glitch_events: got %0d want 0",
                     rcv_cyc.size() + ferr_cyc.size() + perr_cyc.size());
        end
        checks++;
        if (data !== model_data || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_state: got data=%h busy=%b want %h 0",
                     data, busy, model_data);
        end
    endtask

    task automatic test_frame_err();
        int t0;
        clear_q();
        send(8'h3C, 1'b0, 1'b0, t0);
        idle(2 * BAUD);
        checks++;
        if (ferr_cyc.size() !== 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d want 1", ferr_cyc.size());
        end
        if (ferr_cyc.size() > 0) begin
            checks++;
            if (ferr_cyc[0] - t0 !== LAT) begin
                errors++;
                $display("FAIL ferr_latency: got %0d want %0d",
                         ferr_cyc[0] - t0, LAT);
            end
        end
        checks++;
        if (rcv_cyc.size() !== 0) begin
            errors++;
            $display("FAIL ferr_rcv: got %0d want 0", rcv_cyc.size());
        end
        checks++;
        if (data !== model_data) begin
            errors++;
            $display("FAIL ferr_data: got %h want %h", data, model_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int t0;
        d = 8'h5A;
        clear_q();
        rx = 1'b0;
        repeat (BAUD) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BAUD) @(posedge clk);
            #1;
        end
        rx = d[4];
        repeat (BAUD / 2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        model_data = 8'h00;
        checks++;
        if (data !== 8'h00 ||
            {rcv, busy, frame_err, parity_err} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got data=%h flags=%b want 00 0000",
                     data, {rcv, busy, frame_err, parity_err});
        end
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2 * BAUD);
        send(8'h81, 1'b1, 1'b0, t0);
        idle(2 * BAUD);
        model_data = 8'h81;
        checks++;
        if (rcv_cyc.size() !== 1 || ferr_cyc.size() !== 0) begin
            errors++;
            $display("FAIL mid_after_count: got rcv=%0d ferr=%0d want 1 0",
                     rcv_cyc.size(), ferr_cyc.size());
        end
        checks++;
        if (data !== 8'h81) begin
            errors++;
            $display("FAIL mid_after_data: got %h want 81", data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int t0;
        clear_q();
        send(8'h07, 1'b1, 1'b0, t0);
        idle(BAUD);
        model_data = 8'h07;
        checks++;
        if (rcv_cyc.size() !== 1 || data !== 8'h07) begin
            errors++;
            $display("FAIL par_good: got rcv=%0d data=%h want 1 07",
                     rcv_cyc.size(), data);
        end
        clear_q();
        send(8'h00, 1'b1, 1'b0, t0);
        send(8'h07, 1'b1, 1'b1, t0);
        idle(BAUD);
        model_data = 8'h00;
        checks++;
        if (perr_cyc.size() !== 1 || rcv_cyc.size() !== 1) begin
            errors++;
            $display("FAIL par_bad_count: got perr=%0d rcv=%0d want 1 1",
                     perr_cyc.size(), rcv_cyc.size());
        end
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL par_bad_data: got %h want 00", data);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_dat[$];
        int         exp_ferr;
        int         exp_perr;
        int         t0;
        logic [7:0] d;
        bit         stop_good;
        bit         pf;
        int         gap;
        exp_ferr = 0;
        exp_perr = 0;
        clear_q();
        for (int n = 0; n < 12; n++) begin
            d         = 8'($urandom);
            stop_good = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
`else
            pf = 1'b0;
`endif
            send(d, stop_good, pf, t0);
            if (!stop_good) begin
                exp_ferr++;
                gap = BAUD + $urandom_range(0, 8);
            end else if (pf) begin
                exp_perr++;
                gap = $urandom_range(0, 8);
            end else begin
                exp_dat.push_back(d);
                model_data = d;
                gap = $urandom_range(0, 8);
            end
            idle(gap);
        end
        idle(2 * BAUD);
        checks++;
        if (rcv_dat.size() !== exp_dat.size()) begin
            errors++;
            $display("FAIL rand_rcv_count: got %0d want %0d",
                     rcv_dat.size(), exp_dat.size());
        end
        for (int i = 0; i < exp_dat.size() && i < rcv_dat.size(); i++) begin
            checks++;
            if (rcv_dat[i] !== exp_dat[i]) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h want %h",
                         i, rcv_dat[i], exp_dat[i]);
            end
        end
        checks++;
        if (ferr_cyc.size() !== exp_ferr || perr_cyc.size() !== exp_perr) begin
            errors++;
            $display("FAIL rand_err_count: got ferr=%0d perr=%0d want %0d %0d",
                     ferr_cyc.size(), perr_cyc.size(), exp_ferr, exp_perr);
        end
        checks++;
        if (data !== model_data) begin
            errors++;
            $display("FAIL rand_final_data: got %h want %h", data, model_data);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap !== 1'b0) begin
            errors++;
            $display("FAIL exclusive: got overlap=%b want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
